// File: rtl/pe_stream_dispatcher_if.sv
// Stream-in / lane-out bundle for pe_stream_dispatcher.
// master = upstream source + PE array side, slave = the dispatcher itself.
interface pe_stream_dispatcher_if #(
  parameter int DataWidth       = 32,
  parameter int LaneCount       = 7,
  parameter int LaneAddrWidth   = 3,
  parameter int BlockCountWidth = 2
);
  logic                           Mode;
  logic                           DataInValid;
  logic                           DataInRdy;
  logic [DataWidth-1:0]           DataIn;
  logic [LaneCount*DataWidth-1:0] Lane_DataOut;
  logic [LaneCount-1:0]           Lane_Valid;
  logic [LaneCount-1:0]           Lane_Rdy;
  logic [LaneAddrWidth-1:0]       PEAddr;
  logic [BlockCountWidth-1:0]     Block_Counter;
  logic                           TileDone;
  logic                           Busy;
  logic [15:0]                    Perf_StallCount;

  modport master (
    output Mode, DataInValid, DataIn, Lane_Rdy,
    input  DataInRdy, Lane_DataOut, Lane_Valid, PEAddr, Block_Counter,
           TileDone, Busy, Perf_StallCount
  );

  modport slave (
    input  Mode, DataInValid, DataIn, Lane_Rdy,
    output DataInRdy, Lane_DataOut, Lane_Valid, PEAddr, Block_Counter,
           TileDone, Busy, Perf_StallCount
  );
endinterface

// File: rtl/pe_stream_dispatcher.sv
// Round-robin / broadcast scatter of one word stream into LaneCount PE holding registers.
// Optional stall counter enabled by defining PE_DISPATCH_PERF_EN.
module pe_dispatch_lane #(
  parameter int DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 load,
  input  logic                 consume,
  input  logic [DataWidth-1:0] din,
  output logic [DataWidth-1:0] data,
  output logic                 valid,
  output logic                 free
);
  assign free = !valid || consume;

  // Data is held after a drain; only the valid flag drops.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= din;
      valid <= 1'b1;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end
endmodule

module pe_stream_dispatcher #(
  parameter int DataWidth       = 32,
  parameter int LaneCount       = 7,
  parameter int LaneAddrWidth   = 3,
  parameter int FirstBlockElems = 7,
  parameter int NextBlockElems  = 4,
  parameter int BlockCount      = 4,
  parameter int BlockCountWidth = 2
) (
  input logic                  clk,
  input logic                  aclr,
  pe_stream_dispatcher_if.slave bus
);
  localparam int ElemWidth = $clog2(LaneCount + 1);

  typedef enum logic {Idle, Active} tileState_e;

  tileState_e                            state, stateNext;
  logic [LaneCount-1:0][DataWidth-1:0]   laneData;
  logic [LaneCount-1:0]                  laneValid, laneFree, laneLoad;
  logic [LaneAddrWidth-1:0]              peAddr;
  logic [BlockCountWidth-1:0]            blockCnt;
  logic [ElemWidth-1:0]                  elemCnt, blockLimit;
  logic modeReg, effMode, inRdy, accept, lastInBlock, lastBlock, tileEnd, tileDone;

  // The first word of a tile uses the live Mode input; the rest use the latched copy.
  assign effMode     = (state == Active) ? modeReg : bus.Mode;
  assign inRdy       = effMode ? &laneFree : laneFree[peAddr];
  assign accept      = bus.DataInValid && inRdy;
  assign blockLimit  = (blockCnt == '0) ? ElemWidth'(FirstBlockElems) : ElemWidth'(NextBlockElems);
  assign lastInBlock = (elemCnt == blockLimit - 1'b1);
  assign lastBlock   = (blockCnt == BlockCountWidth'(BlockCount - 1));
  assign tileEnd     = accept && lastInBlock && lastBlock;

  for (genvar i = 0; i < LaneCount; i++) begin : gLane
    assign laneLoad[i] = accept && (effMode || (peAddr == LaneAddrWidth'(i)));
    pe_dispatch_lane #(.DataWidth(DataWidth)) uLane (
      .clk     (clk),
      .aclr    (aclr),
      .load    (laneLoad[i]),
      .consume (bus.Lane_Rdy[i]),
      .din     (bus.DataIn),
      .data    (laneData[i]),
      .valid   (laneValid[i]),
      .free    (laneFree[i])
    );
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) state <= Idle;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      Idle:    if (accept && !tileEnd) stateNext = Active;
      Active:  if (tileEnd) stateNext = Idle;
      default: stateNext = Idle;
    endcase
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      peAddr   <= '0;
      blockCnt <= '0;
      elemCnt  <= '0;
      modeReg  <= 1'b0;
      tileDone <= 1'b0;
    end else begin
      tileDone <= tileEnd;
      if (accept) begin
        if (state == Idle) modeReg <= bus.Mode;
        if (tileEnd) begin
          peAddr   <= '0;
          blockCnt <= '0;
          elemCnt  <= '0;
        end else begin
          if (!effMode)
            peAddr <= (peAddr == LaneAddrWidth'(LaneCount - 1)) ? '0 : peAddr + 1'b1;
          if (lastInBlock) begin
            elemCnt  <= '0;
            blockCnt <= blockCnt + 1'b1;
          end else begin
            elemCnt  <= elemCnt + 1'b1;
          end
        end
      end
    end
  end

`ifdef PE_DISPATCH_PERF_EN
  logic [15:0] stallCnt;
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr)
      stallCnt <= '0;
    else if (bus.DataInValid && !inRdy && stallCnt != 16'hFFFF)
      stallCnt <= stallCnt + 1'b1;
  end
  assign bus.Perf_StallCount = stallCnt;
`else
  assign bus.Perf_StallCount = '0;
`endif

  assign bus.DataInRdy     = inRdy;
  assign bus.Lane_DataOut  = laneData;
  assign bus.Lane_Valid    = laneValid;
  assign bus.PEAddr        = peAddr;
  assign bus.Block_Counter = blockCnt;
  assign bus.TileDone      = tileDone;
  assign bus.Busy          = (state == Active);
endmodule

// File: tb/tb_pe_stream_dispatcher.sv
// Directed bench for pe_stream_dispatcher with default parameters.
module tb_pe_stream_dispatcher;
  localparam int DW = 32;
  localparam int LC = 7;

  logic clk = 1'b0;
  logic aclr;
  int   nVec = 0;
  int   nErr = 0;
  logic [31:0] w [0:19];
  logic [31:0] got;
  int   expPe, expBlk, lane;

  pe_stream_dispatcher_if #(.DataWidth(DW), .LaneCount(LC), .LaneAddrWidth(3), .BlockCountWidth(2)) bus ();

  pe_stream_dispatcher dut (.clk(clk), .aclr(aclr), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    bus.DataInValid = 1'b0;
    bus.Mode = 1'b0;
    bus.Lane_Rdy = '1;
    aclr = 1'b1;
    tick();
    aclr = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    aclr = 1'b1;
    bus.DataInValid = 1'b0;
    bus.Mode = 1'b0;
    bus.DataIn = '0;
    bus.Lane_Rdy = '1;
    #3;
    nVec++; if (bus.Lane_Valid !== 7'h00) begin nErr++; $display("FAIL rst_valid got %h exp 00", bus.Lane_Valid); end
    nVec++; if (bus.Lane_DataOut !== '0) begin nErr++; $display("FAIL rst_data got %h exp 0", bus.Lane_DataOut); end
    nVec++; if (bus.PEAddr !== 3'd0) begin nErr++; $display("FAIL rst_peaddr got %0d exp 0", bus.PEAddr); end
    nVec++; if (bus.Block_Counter !== 2'd0) begin nErr++; $display("FAIL rst_block got %0d exp 0", bus.Block_Counter); end
    nVec++; if (bus.TileDone !== 1'b0 || bus.Busy !== 1'b0) begin nErr++; $display("FAIL rst_done_busy got %b%b exp 00", bus.TileDone, bus.Busy); end
    nVec++; if (bus.Perf_StallCount !== 16'd0) begin nErr++; $display("FAIL rst_perf got %0d exp 0", bus.Perf_StallCount); end
    nVec++; if (bus.DataInRdy !== 1'b1) begin nErr++; $display("FAIL rst_rdy got %b exp 1", bus.DataInRdy); end
    tick();
    aclr = 1'b0;
    tick();
  endtask

  task automatic test_scatter_tile;
    for (int k = 1; k <= 19; k++) begin
      bus.DataIn = w[k-1];
      bus.DataInValid = 1'b1;
      #1;
      nVec++; if (bus.DataInRdy !== 1'b1) begin nErr++; $display("FAIL sc_rdy w%0d got %b exp 1", k, bus.DataInRdy); end
      tick();
      lane   = (k - 1) % 7;
      expPe  = (k == 19) ? 0 : k % 7;
      expBlk = (k >= 19) ? 0 : (k >= 15) ? 3 : (k >= 11) ? 2 : (k >= 7) ? 1 : 0;
      got = bus.Lane_DataOut[lane*DW +: DW];
      nVec++; if (bus.Lane_Valid[lane] !== 1'b1 || got !== w[k-1]) begin nErr++; $display("FAIL sc_lane w%0d lane%0d got v=%b %h exp v=1 %h", k, lane, bus.Lane_Valid[lane], got, w[k-1]); end
      nVec++; if (bus.PEAddr !== 3'(expPe)) begin nErr++; $display("FAIL sc_peaddr w%0d got %0d exp %0d", k, bus.PEAddr, expPe); end
      nVec++; if (bus.Block_Counter !== 2'(expBlk)) begin nErr++; $display("FAIL sc_block w%0d got %0d exp %0d", k, bus.Block_Counter, expBlk); end
      nVec++; if (bus.TileDone !== (k == 19) || bus.Busy !== (k != 19)) begin nErr++; $display("FAIL sc_done_busy w%0d got %b%b exp %b%b", k, bus.TileDone, bus.Busy, k == 19, k != 19); end
    end
    bus.DataInValid = 1'b0;
    tick();
    nVec++; if (bus.TileDone !== 1'b0) begin nErr++; $display("FAIL sc_done_pulse got %b exp 0", bus.TileDone); end
    nVec++; if (bus.Lane_Valid !== 7'h00) begin nErr++; $display("FAIL sc_drain got %h exp 00", bus.Lane_Valid); end
  endtask

  task automatic test_backpressure;
    do_reset();
    bus.Lane_Rdy = 7'h7b;
    for (int k = 1; k <= 9; k++) begin
      bus.DataIn = w[k-1];
      bus.DataInValid = 1'b1;
      tick();
    end
    bus.DataIn = w[9];
    for (int c = 0; c < 5; c++) begin
      #1;
      nVec++; if (bus.DataInRdy !== 1'b0) begin nErr++; $display("FAIL bp_rdy c%0d got %b exp 0", c, bus.DataInRdy); end
      tick();
      got = bus.Lane_DataOut[2*DW +: DW];
      nVec++; if (bus.PEAddr !== 3'd2 || bus.Block_Counter !== 2'd1 || got !== w[2]) begin nErr++; $display("FAIL bp_hold c%0d got pe=%0d blk=%0d l2=%h exp pe=2 blk=1 l2=%h", c, bus.PEAddr, bus.Block_Counter, got, w[2]); end
    end
    bus.Lane_Rdy = 7'h7f;
    #1;
    nVec++; if (bus.DataInRdy !== 1'b1) begin nErr++; $display("FAIL bp_release_rdy got %b exp 1", bus.DataInRdy); end
    tick();
    bus.DataInValid = 1'b0;
    got = bus.Lane_DataOut[2*DW +: DW];
    nVec++; if (bus.Lane_Valid[2] !== 1'b1 || got !== w[9] || bus.PEAddr !== 3'd3) begin nErr++; $display("FAIL bp_refill got v=%b %h pe=%0d exp v=1 %h pe=3", bus.Lane_Valid[2], got, bus.PEAddr, w[9]); end
`ifdef PE_DISPATCH_PERF_EN
    nVec++; if (bus.Perf_StallCount !== 16'd5) begin nErr++; $display("FAIL bp_perf got %0d exp 5", bus.Perf_StallCount); end
`else
    nVec++; if (bus.Perf_StallCount !== 16'd0) begin nErr++; $display("FAIL bp_perf got %0d exp 0", bus.Perf_StallCount); end
`endif
  endtask

  task automatic test_reset_mid_tile;
    // Three words of block 1 already accepted by test_backpressure.
    #2;
    aclr = 1'b1;
    #1;
    nVec++; if (bus.Lane_Valid !== 7'h00 || bus.Lane_DataOut !== '0) begin nErr++; $display("FAIL mr_lanes got v=%h d=%h exp 0", bus.Lane_Valid, bus.Lane_DataOut); end
    nVec++; if (bus.PEAddr !== 3'd0 || bus.Block_Counter !== 2'd0 || bus.Busy !== 1'b0 || bus.TileDone !== 1'b0) begin nErr++; $display("FAIL mr_state got pe=%0d blk=%0d busy=%b done=%b exp 0", bus.PEAddr, bus.Block_Counter, bus.Busy, bus.TileDone); end
    nVec++; if (bus.Perf_StallCount !== 16'd0) begin nErr++; $display("FAIL mr_perf got %0d exp 0", bus.Perf_StallCount); end
    tick();
    aclr = 1'b0;
    bus.Lane_Rdy = '1;
    for (int k = 1; k <= 7; k++) begin
      bus.DataIn = w[k+9];
      bus.DataInValid = 1'b1;
      tick();
      got = bus.Lane_DataOut[(k-1)*DW +: DW];
      nVec++; if (got !== w[k+9]) begin nErr++; $display("FAIL mr_lane w%0d got %h exp %h", k, got, w[k+9]); end
      expPe  = k % 7;
      expBlk = (k == 7) ? 1 : 0;
      nVec++; if (bus.PEAddr !== 3'(expPe) || bus.Block_Counter !== 2'(expBlk)) begin nErr++; $display("FAIL mr_addr w%0d got pe=%0d blk=%0d exp pe=%0d blk=%0d", k, bus.PEAddr, bus.Block_Counter, expPe, expBlk); end
    end
    bus.DataInValid = 1'b0;
  endtask

  task automatic test_broadcast;
    do_reset();
    bus.Mode = 1'b1;
    bus.DataIn = 32'h40a0_0000;
    bus.DataInValid = 1'b1;
    #1;
    nVec++; if (bus.DataInRdy !== 1'b1) begin nErr++; $display("FAIL bc_rdy got %b exp 1", bus.DataInRdy); end
    tick();
    bus.DataInValid = 1'b0;
    nVec++; if (bus.Lane_Valid !== 7'h7f || bus.PEAddr !== 3'd0 || bus.Busy !== 1'b1) begin nErr++; $display("FAIL bc_state got v=%h pe=%0d busy=%b exp v=7f pe=0 busy=1", bus.Lane_Valid, bus.PEAddr, bus.Busy); end
    for (int i = 0; i < LC; i++) begin
      got = bus.Lane_DataOut[i*DW +: DW];
      nVec++; if (got !== 32'h40a0_0000) begin nErr++; $display("FAIL bc_lane%0d got %h exp 40a00000", i, got); end
    end
    bus.Lane_Rdy = 7'h3f;
    bus.Mode = 1'b0;
    #1;
    nVec++; if (bus.DataInRdy !== 1'b0) begin nErr++; $display("FAIL bc_block_rdy got %b exp 0", bus.DataInRdy); end
    tick();
    nVec++; if (bus.Lane_Valid !== 7'h40 || bus.DataInRdy !== 1'b0) begin nErr++; $display("FAIL bc_mode_ignored got v=%h rdy=%b exp v=40 rdy=0", bus.Lane_Valid, bus.DataInRdy); end
    bus.Lane_Rdy = '1;
    bus.DataIn = 32'h40c0_0000;
    bus.DataInValid = 1'b1;
    tick();
    bus.DataInValid = 1'b0;
    got = bus.Lane_DataOut[3*DW +: DW];
    nVec++; if (bus.Lane_Valid !== 7'h7f || got !== 32'h40c0_0000 || bus.PEAddr !== 3'd0) begin nErr++; $display("FAIL bc_second got v=%h l3=%h pe=%0d exp v=7f l3=40c00000 pe=0", bus.Lane_Valid, got, bus.PEAddr); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    bus.DataInValid = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      bus.DataIn = w[k-1];
      tick();
    end
    nVec++; if (bus.TileDone !== 1'b1 || bus.DataInRdy !== 1'b1) begin nErr++; $display("FAIL b2b_done got done=%b rdy=%b exp 11", bus.TileDone, bus.DataInRdy); end
    bus.DataIn = 32'h41a0_0000;
    tick();
    bus.DataInValid = 1'b0;
    got = bus.Lane_DataOut[0 +: DW];
    nVec++; if (bus.Lane_Valid[0] !== 1'b1 || got !== 32'h41a0_0000) begin nErr++; $display("FAIL b2b_lane0 got v=%b %h exp v=1 41a00000", bus.Lane_Valid[0], got); end
    nVec++; if (bus.PEAddr !== 3'd1 || bus.Busy !== 1'b1 || bus.TileDone !== 1'b0 || bus.Block_Counter !== 2'd0) begin nErr++; $display("FAIL b2b_state got pe=%0d busy=%b done=%b blk=%0d exp pe=1 busy=1 done=0 blk=0", bus.PEAddr, bus.Busy, bus.TileDone, bus.Block_Counter); end
  endtask

  initial begin
    w[0]  = 32'h3f80_0000; w[1]  = 32'h4000_0000; w[2]  = 32'h4040_0000; w[3]  = 32'h4080_0000;
    w[4]  = 32'h40a0_0000; w[5]  = 32'h40c0_0000; w[6]  = 32'h40e0_0000; w[7]  = 32'h4100_0000;
    w[8]  = 32'h4110_0000; w[9]  = 32'h4120_0000; w[10] = 32'h4130_0000; w[11] = 32'h4140_0000;
    w[12] = 32'h4150_0000; w[13] = 32'h4160_0000; w[14] = 32'h4170_0000; w[15] = 32'h4180_0000;
    w[16] = 32'h4188_0000; w[17] = 32'h4190_0000; w[18] = 32'h4198_0000; w[19] = 32'h41a0_0000;
    test_reset();
    test_scatter_tile();
    test_backpressure();
    test_reset_mid_tile();
    test_broadcast();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
